// File: rtl/hv_ramp_ctrl_pkg.sv
// hv_pkg: shared types and constants for the HV ramp controller and the
// downstream discharge stage.
//   ramp_state_e      : controller FSM encoding (IDLE / RAMP / SETTLE)
//   HV_W              : width of the HVVoltage bus
//   DEF_*             : default parameter values for a 100 MHz clock
//   DISCHARGE_CYCLES  : discharge duration, shared with the discharge stage
package hv_pkg;

   localparam int HV_W = 16;

   localparam int CLK_HZ            = 100_000_000;
   localparam int DEF_RAMP_DIV      = CLK_HZ / 1000;   // one step per ms
   localparam logic [HV_W-1:0] DEF_STEP        = 16'd64;
   localparam logic [HV_W-1:0] DEF_MAX_VOLTAGE = 16'd60000;
   localparam logic [31:0]     DEF_SETTLE_CYCLES = 32'd10_000_000;

   // 100 ms discharge window used by the discharge stage.
   localparam int DISCHARGE_CYCLES = CLK_HZ / 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RAMP   = 2'd1,
      SETTLE = 2'd2
   } ramp_state_e;

endpackage

// File: rtl/hv_ramp_ctrl_if.sv
// hv_ramp_ctrl_if: setpoint command handshake between the host/command
// decoder (master) and the ramp controller (slave).
//   cmd_valid   : master -> slave, new target presented
//   cmd_voltage : master -> slave, requested target setpoint
//   cmd_ready   : slave -> master, target can be accepted this cycle
interface hv_ramp_ctrl_if;
   import hv_pkg::*;

   logic            cmd_valid;
   logic            cmd_ready;
   logic [HV_W-1:0] cmd_voltage;

   modport master (output cmd_valid, output cmd_voltage, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_voltage, output cmd_ready);

endinterface

// File: rtl/hv_ramp_ctrl_tick.sv
// hv_ramp_tick: RAMP_DIV prescaler producing one ramp-step strobe.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : advance the count this cycle
//   clr          : return the count to zero (wins over en)
//   tick         : single-cycle strobe while the count sits at RAMP_DIV-1
//                  and en is high; the count wraps on that same edge
module hv_ramp_tick #(
   parameter int RAMP_DIV = 100000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && !clr && (cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hv_ramp_ctrl.sv
// hv_ramp_ctrl: accepts an HV target over a valid/ready handshake and slews
// HVVoltage towards it by at most STEP every RAMP_DIV cycles.
//   clk, reset_n : 100 MHz clock, asynchronous active-low reset
//   cmd          : setpoint handshake (slave side)
//   hold         : discharge stage busy; freezes ramp-up only
//   abort        : synchronous emergency zero, highest priority
//   HVVoltage    : registered setpoint to HV DAC and discharge stage
//   busy         : high while in RAMP or SETTLE
//   at_target    : one-cycle pulse when the settle period completes
module hv_ramp_ctrl import hv_pkg::*; #(
   parameter int              RAMP_DIV      = DEF_RAMP_DIV,
   parameter logic [HV_W-1:0] STEP          = DEF_STEP,
   parameter logic [HV_W-1:0] MAX_VOLTAGE   = DEF_MAX_VOLTAGE,
   parameter logic [31:0]     SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic            clk,
   input  logic            reset_n,
   hv_ramp_ctrl_if.slave   cmd,
   input  logic            hold,
   input  logic            abort,
   output logic [HV_W-1:0] HVVoltage,
   output logic            busy,
   output logic            at_target
);

   function automatic logic [HV_W-1:0] clamp_target(input logic [HV_W-1:0] v);
      return (v > MAX_VOLTAGE) ? MAX_VOLTAGE : v;
   endfunction

   // 17-bit sum so a large STEP near full scale cannot wrap past the target.
   function automatic logic [HV_W-1:0] step_up(input logic [HV_W-1:0] cur,
                                               input logic [HV_W-1:0] tgt);
      logic [HV_W:0] sum;
      sum = {1'b0, cur} + {1'b0, STEP};
      return (sum >= {1'b0, tgt}) ? tgt : sum[HV_W-1:0];
   endfunction

   // Caller guarantees cur > tgt, so cur - tgt never underflows.
   function automatic logic [HV_W-1:0] step_down(input logic [HV_W-1:0] cur,
                                                 input logic [HV_W-1:0] tgt);
      return ((cur - tgt) <= STEP) ? tgt : cur - STEP;
   endfunction

   ramp_state_e     state, state_nxt;
   logic [HV_W-1:0] target, target_nxt;
   logic [HV_W-1:0] hv_nxt;
   logic [31:0]     settle_cnt, settle_nxt;
   logic            busy_nxt, at_target_nxt;

   logic            accept;
   logic            tick, tick_en, tick_clr;
   logic [HV_W-1:0] clamped;
   logic [HV_W-1:0] eff_target;
   logic [HV_W-1:0] step_val;

   assign clamped = clamp_target(cmd.cmd_voltage);

   // A retarget arriving on a step edge is honoured by that step.
   assign eff_target = accept ? clamped : target;
   assign step_val   = (eff_target > HVVoltage) ? step_up(HVVoltage, eff_target)
                                                : step_down(HVVoltage, eff_target);

   hv_ramp_tick #(.RAMP_DIV(RAMP_DIV)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (tick_en),
      .clr     (tick_clr),
      .tick    (tick)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         target     <= '0;
         HVVoltage  <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         at_target  <= 1'b0;
      end else begin
         state      <= state_nxt;
         target     <= target_nxt;
         HVVoltage  <= hv_nxt;
         settle_cnt <= settle_nxt;
         busy       <= busy_nxt;
         at_target  <= at_target_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt     = state;
      target_nxt    = target;
      hv_nxt        = HVVoltage;
      settle_nxt    = '0;
      at_target_nxt = 1'b0;

      if (abort) begin
         state_nxt  = IDLE;
         target_nxt = '0;
         hv_nxt     = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  target_nxt = clamped;
                  state_nxt  = (clamped == HVVoltage) ? SETTLE : RAMP;
               end
            end
            RAMP: begin
               target_nxt = eff_target;
               if (eff_target == HVVoltage) begin
                  state_nxt = SETTLE;
               end else if (tick) begin
                  hv_nxt = step_val;
                  if (step_val == eff_target) state_nxt = SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_CYCLES - 32'd1) begin
                  state_nxt     = IDLE;
                  at_target_nxt = 1'b1;
               end else begin
                  settle_nxt = settle_cnt + 32'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      busy_nxt = (state_nxt != IDLE);
   end

   // Decoded outputs and prescaler control
   always_comb begin
      cmd.cmd_ready = (state != SETTLE) && !abort;
      accept        = cmd.cmd_valid && cmd.cmd_ready;
      // hold only stalls upward motion; ramp-down keeps running so the
      // discharge stage can follow the falling setpoint.
      tick_en       = (state == RAMP) && !(hold && (target > HVVoltage));
      tick_clr      = abort || (state != RAMP);
   end

endmodule

// File: tb/tb_hv_ramp_ctrl.sv
// tb_hv_ramp_ctrl: directed bench for hv_ramp_ctrl with RAMP_DIV=4,
// STEP=100, MAX_VOLTAGE=4000, SETTLE_CYCLES=8. Expected HVVoltage changes
// and at_target pulses are queued with their edge numbers when a command is
// driven, and popped as the DUT produces them.
module tb_hv_ramp_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hold = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] hv;
   logic        busy;
   logic        at_target;

   hv_ramp_ctrl_if cmd_if ();

   always #5 clk = ~clk;

   hv_ramp_ctrl #(
      .RAMP_DIV      (4),
      .STEP          (16'd100),
      .MAX_VOLTAGE   (16'd4000),
      .SETTLE_CYCLES (32'd8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd       (cmd_if),
      .hold      (hold),
      .abort     (abort),
      .HVVoltage (hv),
      .busy      (busy),
      .at_target (at_target)
   );

   // kind 0 = HVVoltage change to val, kind 1 = at_target pulse
   typedef struct {
      int kind;
      int at_edge;
      int val;
   } ev_t;

   ev_t         exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          edge_no = 0;
   logic [15:0] prev_hv = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic push_exp(input int kind, input int at_edge, input int val);
      exp_q.push_back('{kind, at_edge, val});
   endtask

   task automatic got_ev(input int kind, input int val, input string tag);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_unexpected_event_queue"}, exp_q.size(), 1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_kind"}, kind, e.kind);
         chk({tag, "_edge"}, edge_no, e.at_edge);
         chk({tag, "_value"}, val, e.val);
      end
   endtask

   task automatic clk_edge();
      @(posedge clk);
      #1;
      edge_no++;
   endtask

   task automatic observe(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         clk_edge();
         if (hv !== prev_hv) got_ev(0, int'(hv), tag);
         if (at_target !== 1'b0) got_ev(1, 0, tag);
         prev_hv = hv;
      end
   endtask

   task automatic accept(input int v, input string tag);
      cmd_if.cmd_valid   = 1'b1;
      cmd_if.cmd_voltage = 16'(v);
      #1;
      chk({tag, "_cmd_ready"}, cmd_if.cmd_ready, 1);
      observe(1, tag);
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_pending_events"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int n;
      cmd_if.cmd_valid   = 1'b0;
      cmd_if.cmd_voltage = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hv", hv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_at_target", at_target, 0);
      chk("rst_cmd_ready", cmd_if.cmd_ready, 1);
      reset_n = 1'b1;
      prev_hv = hv;
      edge_no = 0;

      // Ramp up 0 -> 250
      accept(250, "up250");
      n = edge_no;
      push_exp(0, n + 4, 100);
      push_exp(0, n + 8, 200);
      push_exp(0, n + 12, 250);
      push_exp(1, n + 20, 0);
      observe(3, "up250");
      chk("up250_busy_ramp", busy, 1);
      observe(16, "up250");
      chk("up250_busy_settle", busy, 1);
      observe(1, "up250");
      chk("up250_busy_done", busy, 0);
      observe(3, "up250");
      chk_empty("up250");

      // Ramp down 250 -> 0
      accept(0, "down0");
      n = edge_no;
      push_exp(0, n + 4, 150);
      push_exp(0, n + 8, 50);
      push_exp(0, n + 12, 0);
      push_exp(1, n + 20, 0);
      observe(23, "down0");
      chk_empty("down0");

      // Clamp 5000 -> 4000
      accept(5000, "clamp");
      n = edge_no;
      for (int k = 1; k <= 40; k++) push_exp(0, n + 4 * k, 100 * k);
      push_exp(1, n + 168, 0);
      observe(171, "clamp");
      chk("clamp_final_hv", hv, 4000);
      chk_empty("clamp");

      // Abort from IDLE at 4000
      abort = 1'b1;
      push_exp(0, edge_no + 1, 0);
      observe(1, "abort_idle");
      abort = 1'b0;
      chk("abort_idle_busy", busy, 0);
      chk_empty("abort_idle");

      // Hold during ramp-up 0 -> 400
      accept(400, "hold_up");
      n = edge_no;
      push_exp(0, n + 4, 100);
      push_exp(0, n + 18, 200);
      push_exp(0, n + 22, 300);
      push_exp(0, n + 26, 400);
      push_exp(1, n + 34, 0);
      observe(4, "hold_up");
      hold = 1'b1;
      observe(10, "hold_up");
      hold = 1'b0;
      observe(23, "hold_up");
      chk_empty("hold_up");

      // Hold during ramp-down 400 -> 0 has no effect
      accept(0, "hold_down");
      n = edge_no;
      push_exp(0, n + 4, 300);
      push_exp(0, n + 8, 200);
      push_exp(0, n + 12, 100);
      push_exp(0, n + 16, 0);
      push_exp(1, n + 24, 0);
      observe(4, "hold_down");
      hold = 1'b1;
      observe(10, "hold_down");
      hold = 1'b0;
      observe(13, "hold_down");
      chk_empty("hold_down");

      // Abort while ramping at 300, coincident with a new command
      accept(1000, "abort_ramp");
      n = edge_no;
      push_exp(0, n + 4, 100);
      push_exp(0, n + 8, 200);
      push_exp(0, n + 12, 300);
      observe(12, "abort_ramp");
      abort = 1'b1;
      cmd_if.cmd_valid   = 1'b1;
      cmd_if.cmd_voltage = 16'd500;
      #1;
      chk("abort_ramp_cmd_ready", cmd_if.cmd_ready, 0);
      push_exp(0, n + 13, 0);
      observe(1, "abort_ramp");
      abort = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      chk("abort_ramp_busy", busy, 0);
      observe(20, "abort_ramp");
      chk_empty("abort_ramp");

      // Accept 0 at 0 -> SETTLE directly; commands ignored while settling
      accept(0, "direct");
      n = edge_no;
      push_exp(1, n + 8, 0);
      observe(2, "direct");
      chk("direct_busy", busy, 1);
      chk("direct_cmd_ready", cmd_if.cmd_ready, 0);
      cmd_if.cmd_valid   = 1'b1;
      cmd_if.cmd_voltage = 16'd300;
      observe(2, "direct");
      cmd_if.cmd_valid = 1'b0;
      observe(14, "direct");
      chk_empty("direct");

      // Retarget 400 -> 150 while at 200
      accept(400, "retarget");
      n = edge_no;
      push_exp(0, n + 4, 100);
      push_exp(0, n + 8, 200);
      observe(8, "retarget");
      accept(150, "retarget");
      push_exp(0, n + 12, 150);
      push_exp(1, n + 20, 0);
      observe(14, "retarget");
      chk_empty("retarget");

      // Abort on the final settle cycle suppresses at_target
      accept(150, "abort_settle");
      n = edge_no;
      observe(7, "abort_settle");
      abort = 1'b1;
      push_exp(0, n + 8, 0);
      observe(1, "abort_settle");
      abort = 1'b0;
      observe(10, "abort_settle");
      chk_empty("abort_settle");

      // Asynchronous reset mid-ramp
      accept(300, "async_rst");
      n = edge_no;
      push_exp(0, n + 4, 100);
      observe(5, "async_rst");
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_hv", hv, 0);
      chk("async_rst_busy", busy, 0);
      prev_hv = hv;
      clk_edge();
      reset_n = 1'b1;
      observe(10, "async_rst");
      chk_empty("async_rst");

      // Normal operation after reset
      accept(100, "post_rst");
      n = edge_no;
      push_exp(0, n + 4, 100);
      push_exp(1, n + 12, 0);
      observe(15, "post_rst");
      chk_empty("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
